mem_access_unit: RTL and testbench

//  Load/store stage directly downstream of the ALU. It takes the effective address
//  the ALU computes for LW/SW-class instructions, checks alignment, and drives a

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage between the ALU and a variable-latency
// data-memory bus. Checks alignment, runs one req/ack bus cycle with a
// timeout, and returns extended load data or an error flag.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               addr_err_q, addr_err_d;
  logic               bus_err_q, bus_err_d;
  logic               dm_req_q, dm_req_d;
  logic               dm_we_q, dm_we_d;
  logic [3:0]         dm_be_q, dm_be_d;
  logic [31:0]        dm_addr_q, dm_addr_d;
  logic [31:0]        dm_wdata_q, dm_wdata_d;

  // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         misaligned = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = off[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // Byte lanes touched by the access.
  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         byte_en = 4'b1111;
      OP_LH, OP_LHU, OP_SH: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:              byte_en = 4'b0001 << off;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes carry it.
  function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SW:   lane_wdata = wd;
      OP_SH:   lane_wdata = {2{wd[15:0]}};
      OP_SB:   lane_wdata = {4{wd[7:0]}};
      default: lane_wdata = 32'd0;
    endcase
  endfunction

  // Selects the addressed lane(s) of the read word and extends them.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LW:   extract = w;
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'd0, h};
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'd0, b};
      default: extract = 32'd0;
    endcase
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'd0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_be_d      = dm_be_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          op_d        = mem_op;
          off_d       = addr[1:0];
          req_ready_d = 1'b0;
          cnt_d       = '0;
          if (misaligned(mem_op, addr[1:0])) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            addr_err_d   = 1'b1;
          end else begin
            state_d    = S_BUS;
            dm_req_d   = 1'b1;
            dm_we_d    = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
            dm_be_d    = byte_en(mem_op, addr[1:0]);
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_wdata_d = lane_wdata(mem_op, wdata);
          end
        end
      end
      S_BUS: begin
        if (dm_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          cnt_d        = '0;
          dm_req_d     = 1'b0;
          dm_we_d      = 1'b0;
          dm_be_d      = 4'd0;
          dm_addr_d    = 32'd0;
          dm_wdata_d   = 32'd0;
          if (dm_ack) rdata_d   = extract(op_q, off_q, dm_rdata);
          else        bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        cnt_d       = '0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        cnt_d       = '0;
        dm_req_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops every bus/response output at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= 4'd0;
      dm_addr_q    <= 32'd0;
      dm_wdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_be_q      <= dm_be_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;
  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign dm_be      = dm_be_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and random ops, a reactive memory
// bus model, and a scoreboard of expected responses checked by a monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err), .dm_req(dm_req),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        aerr;
    logic        berr;
    int          lat;
    logic        bus;
    logic        we;
    logic [3:0]  be;
    logic [31:0] waddr;
    logic [31:0] wdat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_resp = 0;
  int ack_at = 0;
  int bus_cnt = 0;
  int bus_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the access size/offset rules, in plain arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] word,
                                 input int ack);
    exp_t e;
    int size, o;
    longint v, span;
    bit sgn;
    size = (op == 0 || op == 5) ? 4 : ((op == 1 || op == 2 || op == 6) ? 2 : 1);
    sgn  = (op == 1 || op == 3);
    o    = int'(a % 4);
    e.aerr  = (a % size) != 0;
    e.bus   = !e.aerr;
    e.we    = op >= 5;
    e.be    = 4'(((1 << size) - 1) << o);
    e.waddr = a - 32'(o);
    e.wdat  = (op == 5) ? wd : (op == 6) ? (wd & 32'hFFFF) * 32'h0001_0001
                        : (op == 7) ? (wd & 32'hFF) * 32'h0101_0101 : 32'd0;
    e.berr  = 1'b0;
    e.rdata = 32'd0;
    if (e.aerr) e.lat = 1;
    else if (ack >= 1 && ack <= 16) e.lat = ack + 1;
    else begin e.lat = 17; e.berr = 1'b1; end
    if (!e.aerr && !e.berr && !e.we) begin
      span = longint'(1) << (8 * size);
      v = longint'(word) >> (8 * o);
      v = v % span;
      if (sgn && v >= span / 2) v = v - span;
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // Memory side: acks in the ack_at-th request cycle and checks request fields.
  initial begin
    dm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn || !dm_req) begin
        bus_cnt = 0;
        dm_ack  = 1'b0;
      end else begin
        bus_cnt++;
        bus_len = bus_cnt;
        dm_ack  = (bus_cnt == ack_at);
        chk("bus_cycle_expected", 32'(cur.bus), 32'd1);
        chk("dm_we", 32'(dm_we), 32'(cur.we));
        chk("dm_be", 32'(dm_be), 32'(cur.be));
        chk("dm_addr", dm_addr, cur.waddr);
        chk("dm_wdata", dm_wdata, cur.wdat);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (resp_valid) begin
          n_resp++;
          if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("addr_err", 32'(addr_err), 32'(e.aerr));
            chk("bus_err", 32'(bus_err), 32'(e.berr));
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
          end
        end else begin
          chk("quiet_outputs", 32'((rdata != 0) || addr_err || bus_err), 32'd0);
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int ack);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    cur = model(op, a, wd, word, ack);
    ack_at = ack; dm_rdata = word;
    mem_op = op; addr = a; wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    addr = $urandom; wdata = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int ack);
    int target, n;
    target = n_resp + 1;
    exp_q.push_back(model(op, a, wd, word, ack));
    accept(op, a, wd, word, ack);
    n = 0;
    while (n_resp < target && n < 40) begin @(posedge clk); #1; n++; end
    chk("resp_seen", 32'(n_resp >= target), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  op;
    int ack;
    rstn = 1'b0; req_valid = 1'b0; mem_op = 3'd0; addr = 32'd0; wdata = 32'd0;
    dm_rdata = 32'd0;
    cur = model(3'd0, 32'd2, 32'd0, 32'd0, 1);
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_dm_req", 32'(dm_req), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_dm_be", 32'(dm_be), 32'd0);

    do_op(3'd3, 32'h1003, 32'h0, 32'h80FF1234, 1);   // LB sign
    do_op(3'd4, 32'h1002, 32'h0, 32'h80FF1234, 2);   // LBU
    do_op(3'd2, 32'h1002, 32'h0, 32'h80FF1234, 1);   // LHU
    do_op(3'd1, 32'h1002, 32'h0, 32'h80FF1234, 3);   // LH
    do_op(3'd6, 32'h2002, 32'h1234BEEF, 32'hDEAD0000, 1); // SH
    do_op(3'd0, 32'h1002, 32'h0, 32'h0, 1);          // LW misaligned
    do_op(3'd5, 32'h3000, 32'hCAFEF00D, 32'h0, 0);   // SW timeout
    chk("timeout_req_len", 32'(bus_len), 32'd16);
    do_op(3'd5, 32'h3004, 32'h01234567, 32'h0, 16);  // ack on last cycle
    chk("late_ack_req_len", 32'(bus_len), 32'd16);

    // Reset during a bus cycle that would ack in its third cycle.
    accept(3'd0, 32'h4000, 32'h0, 32'h11112222, 3);
    @(posedge clk); @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst_dm_req_drop", 32'(dm_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("no_resp_after_rst", 32'(n_resp), 32'd8);
    do_op(3'd0, 32'h4000, 32'h0, 32'h89ABCDEF, 2);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 0 || op == 5) a[1:0] = 2'b00;
        else if (op == 1 || op == 2 || op == 6) a[0] = 1'b0;
      end
      ack = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
      do_op(op, a, $urandom, $urandom, ack);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
